// File: rtl/alu_or_issue.sv
// Issue/retire stage around the combinational segmented-OR unit: small request
// FIFO, head exposure to the OR unit, and a registered result slot with handshake.
module alu_or_issue #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_din,
   input  logic [2:0]       in_funct,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      or_din,
   output logic [2:0]       or_funct,
   input  logic [31:0]      or_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [7:0]       err_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [31:0]      din_mem   [DEPTH];
   logic [2:0]       funct_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem   [DEPTH];

   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;

   logic             out_valid_reg;
   logic [31:0]      out_res_reg;
   logic [TAG_W-1:0] out_tag_reg;
   logic             out_err_reg;
   logic [7:0]       err_cnt_reg;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [31:0]      head_din;
   logic [2:0]       head_funct;
   logic [TAG_W-1:0] head_tag;
   logic             head_illegal;

   assign full         = (count_reg == CNT_FULL);
   assign empty        = (count_reg == '0);
   assign in_ready     = !full && !rst;
   assign push         = in_valid && in_ready;
   // The pop is allowed to see out_ready so a full slot can be refilled in the same cycle it drains.
   assign pop          = !empty && (!out_valid_reg || out_ready);

   assign head_din     = din_mem[rd_ptr_reg];
   assign head_funct   = funct_mem[rd_ptr_reg];
   assign head_tag     = tag_mem[rd_ptr_reg];
   assign head_illegal = (head_funct > 3'd4);

   assign or_din       = empty ? 32'd0 : head_din;
   assign or_funct     = empty ? 3'd0  : head_funct;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
               din_mem[gi]   <= in_din;
               funct_mem[gi] <= in_funct;
               tag_mem[gi]   <= in_tag;
            end
         end
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         count_reg <= count_next;
      end
   end

   // Illegal codes retire with a zero result instead of whatever the OR unit produced.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_res_reg   <= '0;
         out_tag_reg   <= '0;
         out_err_reg   <= 1'b0;
      end else if (pop) begin
         out_valid_reg <= 1'b1;
         out_res_reg   <= head_illegal ? 32'd0 : or_res;
         out_tag_reg   <= head_tag;
         out_err_reg   <= head_illegal;
      end else if (out_valid_reg && out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_reg <= '0;
      end else if (pop && head_illegal && (err_cnt_reg != 8'hFF)) begin
         err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_res   = out_res_reg;
   assign out_tag   = out_tag_reg;
   assign out_err   = out_err_reg;
   assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_alu_or_issue.sv
// Bench for alu_or_issue: constant vector table, hand sequences for backpressure,
// streaming and reset, plus randomized traffic checked against a queue scoreboard.
module tb_alu_or_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_din;
   logic [2:0]  in_funct;
   logic [3:0]  in_tag;
   logic [31:0] or_din;
   logic [2:0]  or_funct;
   logic [31:0] or_res;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [3:0]  out_tag;
   logic        out_err;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_or_issue #(.DEPTH(2), .TAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_din(in_din), .in_funct(in_funct), .in_tag(in_tag),
      .or_din(or_din), .or_funct(or_funct), .or_res(or_res),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_tag(out_tag), .out_err(out_err),
      .err_cnt(err_cnt)
   );

   // OR unit model: any set bit marks its whole segment, reported at the segment's lowest bit.
   function automatic logic [31:0] seg_or(input logic [31:0] d, input logic [2:0] f);
      logic [31:0] r;
      int sz;
      r = '0;
      if (f > 3'd4) return 32'hDEAD_BEEF;
      sz = 1 << f;
      for (int b = 0; b < 32; b++)
         if (d[b]) r[b - (b % sz)] = 1'b1;
      return r;
   endfunction

   always_comb or_res = seg_or(or_din, or_funct);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   exp_ill = 0;
   int   cyc_cnt = 0;
   int   retired = 0;
   int   first_ret = 0;
   int   last_ret = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_res;
   logic [3:0]  prev_tag;
   logic        prev_err;

   // Scoreboard: every accepted request must retire once, in order, with the model's result.
   always @(negedge clk) begin
      exp_t e;
      cyc_cnt++;
      if (rst) begin
         q.delete();
         exp_ill   = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_res", out_res, prev_res);
            check("hold_tag", 32'(out_tag), 32'(prev_tag));
            check("hold_err", 32'(out_err), 32'(prev_err));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got tag %h res %h, required no result", out_tag, out_res);
            end else begin
               e = q.pop_front();
               check("sb_res", out_res, e.res);
               check("sb_tag", 32'(out_tag), 32'(e.tag));
               check("sb_err", 32'(out_err), 32'(e.err));
               if (retired == 0) first_ret = cyc_cnt;
               last_ret = cyc_cnt;
               retired++;
            end
         end
         if (in_valid && in_ready) begin
            e.err = (in_funct > 3'd4);
            e.res = e.err ? 32'd0 : seg_or(in_din, in_funct);
            e.tag = in_tag;
            q.push_back(e);
            if (e.err && exp_ill < 255) exp_ill++;
         end
         prev_hold = out_valid && !out_ready;
         prev_res  = out_res;
         prev_tag  = out_tag;
         prev_err  = out_err;
      end
   end

   typedef struct {
      logic [31:0] din;
      logic [2:0]  funct;
      logic [31:0] res;
      logic        err;
   } vec_t;

   vec_t tbl[10];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 500) begin
         cyc();
         n++;
      end
      total++;
      if (n >= 500) begin
         bad++;
         $display("FAIL %s: drain timed out with %0d pending, required 0", name, q.size());
      end
   endtask

   task automatic wait_out(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         cyc();
         n++;
      end
      check(name, 32'(out_valid), 32'd1);
   endtask

   initial begin
      int acc;
      int n;
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int n;
      tbl[0] = '{32'h0000_0300, 3'd2, 32'h0000_0100, 1'b0};
      tbl[1] = '{32'h1234_5678, 3'd0, 32'h1234_5678, 1'b0};
      tbl[2] = '{32'hC000_000C, 3'd1, 32'h4000_0004, 1'b0};
      tbl[3] = '{32'h0080_0001, 3'd3, 32'h0001_0001, 1'b0};
      tbl[4] = '{32'h8000_0000, 3'd4, 32'h0001_0000, 1'b0};
      tbl[5] = '{32'hFFFF_FFFF, 3'd4, 32'h0001_0001, 1'b0};
      tbl[6] = '{32'h0000_0000, 3'd3, 32'h0000_0000, 1'b0};
      tbl[7] = '{32'hFFFF_FFFF, 3'd2, 32'h1111_1111, 1'b0};
      tbl[8] = '{32'h0000_ABCD, 3'd7, 32'h0000_0000, 1'b1};
      tbl[9] = '{32'h0000_0001, 3'd5, 32'h0000_0000, 1'b1};

      rst = 1'b1; in_valid = 1'b1; in_din = 32'h0000_0300; in_funct = 3'd2; in_tag = 4'd1; out_ready = 1'b0;
      cyc();
      cyc();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_or_din", or_din, 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      cyc();

      // Table: each op alone, out_valid must appear exactly after the second edge.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_din = tbl[i].din; in_funct = tbl[i].funct; in_tag = 4'(i + 5);
         out_ready = 1'b0;
         cyc();
         in_valid = 1'b0;
         check($sformatf("vec%0d_lat_e0", i), 32'(out_valid), 32'd0);
         cyc();
         check($sformatf("vec%0d_lat_e1", i), 32'(out_valid), 32'd1);
         check($sformatf("vec%0d_res", i), out_res, tbl[i].res);
         check($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(i + 5));
         check($sformatf("vec%0d_err", i), 32'(out_err), 32'(tbl[i].err));
         out_ready = 1'b1;
         cyc();
         out_ready = 1'b0;
      end
      check("err_cnt_after_table", 32'(err_cnt), 32'd2);

      // Backpressure: FIFO plus slot absorb three requests.
      acc = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_din = $urandom; in_funct = 3'd3; in_tag = 4'(acc);
         if (in_ready) acc++;
         cyc();
      end
      in_valid = 1'b0;
      check("bp_accepted", 32'(acc), 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bp_ret%0d_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp_ret%0d_tag", k), 32'(out_tag), 32'(k));
         cyc();
      end
      check("bp_empty_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Streaming: 16 ops back to back must retire on 16 consecutive cycles.
      retired = 0;
      out_ready = 1'b1;
      acc = 0;
      n = 0;
      while (acc < 16 && n < 100) begin
         in_valid = 1'b1; in_din = $urandom; in_funct = 3'd3; in_tag = 4'(acc);
         if (in_ready) acc++;
         cyc();
         n++;
      end
      check("stream_push_cycles", 32'(n), 32'd16);
      drain("stream_drain");
      check("stream_retired", 32'(retired), 32'd16);
      check("stream_no_bubble", 32'(last_ret - first_ret), 32'd15);

      // Random traffic against the scoreboard.
      for (int k = 0; k < 400; k++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_din    = $urandom;
         in_funct  = 3'($urandom_range(0, 7));
         in_tag    = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      drain("rand_drain");
      check("rand_err_cnt", 32'(err_cnt), 32'(exp_ill));

      // Saturation: 300 more illegal ops.
      acc = 0;
      n = 0;
      out_ready = 1'b1;
      while (acc < 300 && n < 1000) begin
         in_valid = 1'b1; in_din = $urandom; in_funct = 3'($urandom_range(5, 7)); in_tag = 4'(acc);
         if (in_ready) acc++;
         cyc();
         n++;
      end
      drain("sat_drain");
      check("sat_err_cnt", 32'(err_cnt), 32'd255);

      // Mid-stream reset with FIFO full and slot occupied.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_din = 32'hFFFF_0000; in_funct = 3'd4; in_tag = 4'(k + 8);
         cyc();
      end
      check("mr_full_valid", 32'(out_valid), 32'd1);
      check("mr_full_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("mr_out_valid", 32'(out_valid), 32'd0);
      check("mr_or_din", or_din, 32'd0);
      check("mr_in_ready", 32'(in_ready), 32'd1);
      check("mr_err_cnt", 32'(err_cnt), 32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check($sformatf("mr_stale%0d", k), 32'(out_valid), 32'd0);
      end

      in_valid = 1'b1; in_din = 32'h0000_0300; in_funct = 3'd2; in_tag = 4'd5; out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      wait_out("post_mr_valid");
      check("post_mr_res", out_res, 32'h0000_0100);
      check("post_mr_tag", 32'(out_tag), 32'd5);
      drain("final_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
